// File: rtl/vga_sprite_renderer_if.sv
// Upstream video timing, buttons and the rendered output of vga_sprite_renderer.
interface vga_sprite_renderer_if;
  logic        h_sync_in, v_sync_in;
  logic [15:0] x_in, y_in;
  logic        end_of_line, end_of_frame;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        h_sync, v_sync;
  logic [11:0] rgb;
  logic [15:0] box_x, box_y;

  modport master (
    output h_sync_in, v_sync_in, x_in, y_in, end_of_line, end_of_frame,
           btn_up, btn_down, btn_left, btn_right,
    input  h_sync, v_sync, rgb, box_x, box_y
  );
  modport slave (
    input  h_sync_in, v_sync_in, x_in, y_in, end_of_line, end_of_frame,
           btn_up, btn_down, btn_left, btn_right,
    output h_sync, v_sync, rgb, box_x, box_y
  );
endinterface

// File: rtl/vga_sprite_renderer.sv
// Overlays a button-driven square sprite on an upstream VGA stream, 2-clock latency.
// Define COLOR_BARS_EN to draw 8 vertical colour bars behind the sprite.
module vga_sprite_renderer #(
  parameter int          H_PW      = 96,
  parameter int          H_BP      = 48,
  parameter int          H_DISP    = 640,
  parameter int          V_PW      = 2,
  parameter int          V_BP      = 29,
  parameter int          V_DISP    = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 4,
  parameter logic [11:0] BOX_COLOR = 12'hF80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_sprite_renderer_if.slave  bus
);
  localparam logic [15:0]        H_START = 16'(H_PW + H_BP);
  localparam logic [15:0]        H_END   = 16'(H_PW + H_BP + H_DISP);
  localparam logic [15:0]        V_START = 16'(V_PW + V_BP);
  localparam logic [15:0]        V_END   = 16'(V_PW + V_BP + V_DISP);
  localparam logic [15:0]        BOX_X0  = 16'((H_DISP - BOX_SIZE) / 2);
  localparam logic [15:0]        BOX_Y0  = 16'((V_DISP - BOX_SIZE) / 2);
  localparam logic signed [16:0] STEP_S  = 17'(STEP);
  localparam logic signed [16:0] X_MAX   = 17'(H_DISP - BOX_SIZE);
  localparam logic signed [16:0] Y_MAX   = 17'(V_DISP - BOX_SIZE);

  logic [15:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
  logic        locked_q, locked_d, active_d;
  logic [15:0] x_s1_q, y_s1_q;
  logic        act_s1_q, hs_s1_q, vs_s1_q;
  logic [11:0] rgb_q, rgb_d, bg;
  logic        hs_q, vs_q;
  logic [3:0]  btn_meta_q, btn_s_q;   // {up, down, left, right}
  logic [15:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic signed [16:0] dx, dy, nx, ny;
  logic        frame_end, in_box;

  assign frame_end = bus.end_of_line & bus.end_of_frame;

  always_comb begin
    h_pos_d  = bus.end_of_line ? 16'd0 : h_pos_q + 16'd1;
    v_pos_d  = v_pos_q;
    if (bus.end_of_line) v_pos_d = bus.end_of_frame ? 16'd0 : v_pos_q + 16'd1;
    // Output stays dark until the first frame boundary aligns our counters.
    locked_d = locked_q | frame_end;
    active_d = locked_q && (h_pos_q >= H_START) && (h_pos_q < H_END) &&
               (v_pos_q >= V_START) && (v_pos_q < V_END);
  end

  // 17-bit signed step so a move below zero is seen and clamped, never wrapped.
  always_comb begin
    dx = '0;
    dy = '0;
    if (btn_s_q[0] && !btn_s_q[1])      dx = STEP_S;
    else if (btn_s_q[1] && !btn_s_q[0]) dx = -STEP_S;
    if (btn_s_q[2] && !btn_s_q[3])      dy = STEP_S;
    else if (btn_s_q[3] && !btn_s_q[2]) dy = -STEP_S;
    nx = $signed({1'b0, box_x_q}) + dx;
    ny = $signed({1'b0, box_y_q}) + dy;
    if (nx < 0)          nx = '0;
    else if (nx > X_MAX) nx = X_MAX;
    if (ny < 0)          ny = '0;
    else if (ny > Y_MAX) ny = Y_MAX;
    box_x_d = frame_end ? 16'(nx) : box_x_q;
    box_y_d = frame_end ? 16'(ny) : box_y_q;
  end

  always_comb begin
    in_box = (x_s1_q >= box_x_q) && (17'(x_s1_q) < 17'(box_x_q) + 17'(BOX_SIZE)) &&
             (y_s1_q >= box_y_q) && (17'(y_s1_q) < 17'(box_y_q) + 17'(BOX_SIZE));
`ifdef COLOR_BARS_EN
    case (x_s1_q / 16'd80)
      16'd0:   bg = 12'hFFF;
      16'd1:   bg = 12'hFF0;
      16'd2:   bg = 12'h0FF;
      16'd3:   bg = 12'h0F0;
      16'd4:   bg = 12'hF0F;
      16'd5:   bg = 12'hF00;
      16'd6:   bg = 12'h00F;
      default: bg = 12'h000;
    endcase
`else
    bg = 12'h000;
`endif
    rgb_d = !act_s1_q ? 12'h000 : (in_box ? BOX_COLOR : bg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos_q    <= '0;
      v_pos_q    <= '0;
      locked_q   <= 1'b0;
      x_s1_q     <= '0;
      y_s1_q     <= '0;
      act_s1_q   <= 1'b0;
      hs_s1_q    <= 1'b1;
      vs_s1_q    <= 1'b1;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      btn_meta_q <= '0;
      btn_s_q    <= '0;
      box_x_q    <= BOX_X0;
      box_y_q    <= BOX_Y0;
    end else begin
      h_pos_q    <= h_pos_d;
      v_pos_q    <= v_pos_d;
      locked_q   <= locked_d;
      x_s1_q     <= bus.x_in;
      y_s1_q     <= bus.y_in;
      act_s1_q   <= active_d;
      hs_s1_q    <= bus.h_sync_in;
      vs_s1_q    <= bus.v_sync_in;
      rgb_q      <= rgb_d;
      hs_q       <= hs_s1_q;
      vs_q       <= vs_s1_q;
      btn_meta_q <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
      btn_s_q    <= btn_meta_q;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
    end
  end

  assign bus.h_sync = hs_q;
  assign bus.v_sync = vs_q;
  assign bus.rgb    = rgb_q;
  assign bus.box_x  = box_x_q;
  assign bus.box_y  = box_y_q;
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Randomized bench for vga_sprite_renderer on a shrunken raster, against a pixel-level model.
module tb_vga_sprite_renderer;
  localparam int H_PW = 2, H_BP = 2, H_DISP = 24, H_FP = 2;
  localparam int V_PW = 1, V_BP = 1, V_DISP = 12, V_FP = 1;
  localparam int BOX = 4, STEP = 2;
  localparam logic [11:0] COL = 12'hF80;
  localparam int H_ST = H_PW + H_BP, H_TOT = H_ST + H_DISP + H_FP;
  localparam int V_ST = V_PW + V_BP, V_TOT = V_ST + V_DISP + V_FP;
  localparam int X0 = (H_DISP - BOX) / 2, Y0 = (V_DISP - BOX) / 2;
  localparam int XMAX = H_DISP - BOX, YMAX = V_DISP - BOX;
`ifdef COLOR_BARS_EN
  localparam bit BARS = 1'b1;
`else
  localparam bit BARS = 1'b0;
`endif

  typedef struct packed { logic hs; logic vs; logic [11:0] rgb; } exp_t;
  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sprite_renderer_if bus();
  vga_sprite_renderer #(
    .H_PW(H_PW), .H_BP(H_BP), .H_DISP(H_DISP), .V_PW(V_PW), .V_BP(V_BP), .V_DISP(V_DISP),
    .BOX_SIZE(BOX), .STEP(STEP), .BOX_COLOR(COL)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_chk = 0, n_err = 0;
  int   mbx, mby, lit, box_hits;
  bit   mlocked;
  exp_t q[$];
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic exp_t model(input int col, input int line);
    exp_t e;
    int   x = col - H_ST, y = line - V_ST;
    bit   vis = (col >= H_ST) && (col < H_ST + H_DISP) && (line >= V_ST) && (line < V_ST + V_DISP);
    e.hs = (col >= H_PW);
    e.vs = (line >= V_PW);
    if (!(mlocked && vis))                                           e.rgb = 12'h000;
    else if (x >= mbx && x < mbx + BOX && y >= mby && y < mby + BOX) e.rgb = COL;
    else if (BARS)                                                   e.rgb = bars[(x / 80) % 8];
    else                                                             e.rgb = 12'h000;
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"},  32'(bus.h_sync), 32'd1);
    chk({tag, "_vs"},  32'(bus.v_sync), 32'd1);
    chk({tag, "_rgb"}, 32'(bus.rgb),    32'd0);
    chk({tag, "_bx"},  32'(bus.box_x),  32'(X0));
    chk({tag, "_by"},  32'(bus.box_y),  32'(Y0));
  endtask

  // One pixel clock: check the output due now, optionally pulse reset, drive the next pixel.
  task automatic step(input int col, input int line, input logic [3:0] btn, input bit do_rst);
    exp_t e;
    int   dx, dy;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("hsync", 32'(bus.h_sync), 32'(e.hs));
      chk("vsync", 32'(bus.v_sync), 32'(e.vs));
      chk("rgb",   32'(bus.rgb),    32'(e.rgb));
      if (bus.rgb == COL)     box_hits++;
      if (bus.rgb != 12'h000) lit++;
    end
    if (col == 0) begin
      chk("box_x", 32'(bus.box_x), 32'(mbx));
      chk("box_y", 32'(bus.box_y), 32'(mby));
    end
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      mlocked = 1'b0; mbx = X0; mby = Y0; lit = 0;
      q.delete();
      q.push_back(IDLE);
      rst_n = 1'b1;
    end
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = btn;
    bus.h_sync_in    = (col >= H_PW);
    bus.v_sync_in    = (line >= V_PW);
    bus.x_in         = ((col >= H_ST) && (col < H_ST + H_DISP) && (line >= V_ST) && (line < V_ST + V_DISP)) ? 16'(col - H_ST) : 16'd0;
    bus.y_in         = ((col >= H_ST) && (col < H_ST + H_DISP) && (line >= V_ST) && (line < V_ST + V_DISP)) ? 16'(line - V_ST) : 16'd0;
    bus.end_of_line  = (col == H_TOT - 1);
    bus.end_of_frame = (line == V_TOT - 1);
    q.push_back(model(col, line));
    if (col == H_TOT - 1 && line == V_TOT - 1) begin
      dx = (btn[0] && !btn[1]) ? STEP : (btn[1] && !btn[0]) ? -STEP : 0;
      dy = (btn[2] && !btn[3]) ? STEP : (btn[3] && !btn[2]) ? -STEP : 0;
      mbx = clamp(mbx + dx, XMAX);
      mby = clamp(mby + dy, YMAX);
      mlocked = 1'b1;
    end
  endtask

  // btn < 0 picks a random button set per frame; rst_line >= 0 pulses reset mid-line in the first frame.
  task automatic run_frames(input int n, input int btn, input int rst_line);
    logic [3:0] b;
    for (int f = 0; f < n; f++) begin
      b = (btn < 0) ? 4'($urandom_range(0, 15)) : 4'(btn);
      for (int ln = 0; ln < V_TOT; ln++)
        for (int c = 0; c < H_TOT; c++)
          step(c, ln, b, (rst_line >= 0) && (f == 0) && (ln == rst_line) && (c == H_ST + H_DISP / 2));
    end
  endtask

  task automatic chk_box(input string tag, input int ex, input int ey);
    @(posedge clk);
    #1;
    chk({tag, "_x"}, 32'(bus.box_x), 32'(ex));
    chk({tag, "_y"}, 32'(bus.box_y), 32'(ey));
  endtask

  initial begin
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    bus.h_sync_in = 1'b1; bus.v_sync_in = 1'b1;
    bus.x_in = '0; bus.y_in = '0;
    bus.end_of_line = 1'b0; bus.end_of_frame = 1'b0;
    mbx = X0; mby = Y0; mlocked = 1'b0; lit = 0; box_hits = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    q.push_back(IDLE);
    q.push_back(IDLE);

    lit = 0;
    run_frames(1, 0, -1);
    chk("unlocked_lit", 32'(lit), 32'd0);
    box_hits = 0;
    run_frames(1, 0, -1);
    chk("box_pixels", 32'(box_hits), 32'(BOX * BOX));

    for (int i = 1; i <= 3; i++) begin
      run_frames(1, 4'b0001, -1);
      chk_box("right", X0 + STEP * i, Y0);
    end
    run_frames(2, 4'b0011, -1);
    chk_box("left_right", X0 + 3 * STEP, Y0);
    run_frames(5, 4'b1000, -1);
    chk_box("up_sat", X0 + 3 * STEP, 0);
    run_frames(10, 4'b0001, -1);
    chk_box("right_sat", XMAX, 0);

    run_frames(20, -1, -1);

    run_frames(1, 0, V_ST + 6);
    chk("post_reset_lit", 32'(lit), 32'd0);
    box_hits = 0;
    run_frames(1, 0, -1);
    chk("relock_box_pixels", 32'(box_hits), 32'(BOX * BOX));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
